// File: rtl/mips_cpu_bus_arbiter.sv
// ============================================================================
// mips_cpu_bus_arbiter: shares one memory bus master between fetch and data
// ports, holds transfers through waitrequest, and flags stalled transfers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mips_cpu_bus_arbiter #(
  parameter bit FETCH_PRIORITY = 1'b0,
  parameter int MAX_WAIT       = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_done,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        error
);

  // The wait counter holds stalls already seen, so the abort fires on the
  // edge where it equals MAX_WAIT-1 with waitrequest still high.
  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        owner_fetch;
  logic [15:0] wait_cnt;
  logic        pick_fetch;
  logic        stall_expired;

  always_comb begin
    pick_fetch    = f_req && (!d_req || FETCH_PRIORITY);
    stall_expired = waitrequest && (wait_cnt == WAIT_LAST);
    state_next    = state;
    case (state)
      IDLE:    if (f_req || d_req) state_next = ACCESS;
      ACCESS:  if (!waitrequest || stall_expired) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address     <= 32'h0;
      writedata   <= 32'h0;
      byteenable  <= 4'h0;
      read        <= 1'b0;
      write       <= 1'b0;
      f_done      <= 1'b0;
      d_done      <= 1'b0;
      f_rdata     <= 32'h0;
      d_rdata     <= 32'h0;
      error       <= 1'b0;
      owner_fetch <= 1'b0;
      wait_cnt    <= 16'h0;
    end else begin
      f_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (f_req || d_req) begin
            owner_fetch <= pick_fetch;
            wait_cnt    <= 16'h0;
            if (pick_fetch) begin
              address    <= f_addr;
              writedata  <= 32'h0;
              byteenable <= 4'hF;
              write      <= 1'b0;
              read       <= 1'b1;
            end else begin
              address    <= d_addr;
              writedata  <= d_wdata;
              byteenable <= d_be;
              write      <= d_we;
              read       <= !d_we;
            end
          end
        end
        ACCESS: begin
          if (!waitrequest) begin
            read  <= 1'b0;
            write <= 1'b0;
            if (owner_fetch) begin
              f_done  <= 1'b1;
              f_rdata <= readdata;
            end else begin
              d_done  <= 1'b1;
              d_rdata <= write ? 32'h0 : readdata;
            end
          end else if (stall_expired) begin
            // Hung memory: give the owner a zero result and latch the fault.
            error <= 1'b1;
            read  <= 1'b0;
            write <= 1'b0;
            if (owner_fetch) begin
              f_done  <= 1'b1;
              f_rdata <= 32'h0;
            end else begin
              d_done  <= 1'b1;
              d_rdata <= 32'h0;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'h1;
          end
        end
        DONE:    wait_cnt <= 16'h0;
        default: wait_cnt <= 16'h0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Testbench for mips_cpu_bus_arbiter: directed vector table, corner-case
// sequences, and randomized traffic against a transaction-level model.
`default_nettype none

module tb_mips_cpu_bus_arbiter;

  localparam int MAXW = 4;

  typedef struct packed {
    logic        f_done;
    logic [31:0] f_rdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        busy;
    logic        error;
  } out_t;

  typedef struct {
    logic        f_req;
    logic [31:0] f_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        wr;
    logic [31:0] rd;
    out_t        exp;
  } vec_t;

  typedef struct {
    int          phase;      // 0 idle, 1 transfer on bus, 2 completion cycle
    bit          fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          stalls;
    bit          err;
    bit          fd;
    bit          dd;
    logic [31:0] frd;
    logic [31:0] drd;
  } mdl_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, d_req, d_we, waitrequest;
  logic [31:0] f_addr, d_addr, d_wdata, readdata;
  logic [3:0]  d_be;

  logic        f_done_0, d_done_0, write_0, read_0, busy_0, error_0;
  logic [31:0] f_rdata_0, d_rdata_0, address_0, writedata_0;
  logic [3:0]  byteenable_0;
  logic        f_done_1, d_done_1, write_1, read_1, busy_1, error_1;
  logic [31:0] f_rdata_1, d_rdata_1, address_1, writedata_1;
  logic [3:0]  byteenable_1;

  out_t out0, out1;
  assign out0 = {f_done_0, f_rdata_0, d_done_0, d_rdata_0, address_0, write_0, read_0,
                 writedata_0, byteenable_0, busy_0, error_0};
  assign out1 = {f_done_1, f_rdata_1, d_done_1, d_rdata_1, address_1, write_1, read_1,
                 writedata_1, byteenable_1, busy_1, error_1};

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mips_cpu_bus_arbiter #(.FETCH_PRIORITY(1'b0), .MAX_WAIT(MAXW)) dut0 (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done_0), .f_rdata(f_rdata_0),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_done(d_done_0), .d_rdata(d_rdata_0),
    .address(address_0), .write(write_0), .read(read_0), .waitrequest(waitrequest),
    .writedata(writedata_0), .byteenable(byteenable_0), .readdata(readdata),
    .busy(busy_0), .error(error_0)
  );

  mips_cpu_bus_arbiter #(.FETCH_PRIORITY(1'b1), .MAX_WAIT(MAXW)) dut1 (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done_1), .f_rdata(f_rdata_1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_done(d_done_1), .d_rdata(d_rdata_1),
    .address(address_1), .write(write_1), .read(read_1), .waitrequest(waitrequest),
    .writedata(writedata_1), .byteenable(byteenable_1), .readdata(readdata),
    .busy(busy_1), .error(error_1)
  );

  function automatic out_t eo(bit rd, bit wr, logic [31:0] addr, logic [31:0] wd,
                              logic [3:0] be, bit fd, logic [31:0] frd, bit dd,
                              logic [31:0] drd, bit bsy, bit err);
    out_t o;
    o.read = rd; o.write = wr; o.address = addr; o.writedata = wd; o.byteenable = be;
    o.f_done = fd; o.f_rdata = frd; o.d_done = dd; o.d_rdata = drd;
    o.busy = bsy; o.error = err;
    return o;
  endfunction

  function automatic vec_t mk(bit fr, logic [31:0] fa, bit dr, bit dw, logic [31:0] da,
                              logic [31:0] dwd, logic [3:0] db, bit wr, logic [31:0] rd,
                              out_t e);
    vec_t v;
    v.f_req = fr; v.f_addr = fa; v.d_req = dr; v.d_we = dw; v.d_addr = da;
    v.d_wdata = dwd; v.d_be = db; v.wr = wr; v.rd = rd; v.exp = e;
    return v;
  endfunction

  // Payload fields are only meaningful while a strobe or done says so.
  task automatic check(string name, out_t act, out_t exp, bit full);
    out_t a = act;
    out_t e = exp;
    if (!full) begin
      if (!(e.read || e.write)) begin
        a.address = '0; e.address = '0; a.byteenable = '0; e.byteenable = '0;
      end
      if (!e.write)  begin a.writedata = '0; e.writedata = '0; end
      if (!e.f_done) begin a.f_rdata = '0;   e.f_rdata = '0;   end
      if (!e.d_done) begin a.d_rdata = '0;   e.d_rdata = '0;   end
    end
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    f_req = 0; d_req = 0; d_we = 0; waitrequest = 0;
    f_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; readdata = 0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  function automatic mdl_t mreset();
    mdl_t m;
    m.phase = 0; m.fetch = 0; m.we = 0; m.addr = 0; m.wdata = 0; m.be = 0;
    m.stalls = 0; m.err = 0; m.fd = 0; m.dd = 0; m.frd = 0; m.drd = 0;
    return m;
  endfunction

  // One clock of the transaction model: grant, serve/stall/abort, retire.
  function automatic mdl_t mstep(mdl_t m, bit prio);
    mdl_t n = m;
    n.fd = 0; n.dd = 0;
    if (m.phase == 0) begin
      if (f_req || d_req) begin
        n.fetch = f_req && (!d_req || prio);
        if (n.fetch) begin
          n.addr = f_addr; n.we = 0; n.be = 4'hF; n.wdata = 0;
        end else begin
          n.addr = d_addr; n.we = d_we; n.be = d_be; n.wdata = d_wdata;
        end
        n.stalls = 0;
        n.phase  = 1;
      end
    end else if (m.phase == 1) begin
      if (!waitrequest) begin
        if (m.fetch) begin n.fd = 1; n.frd = readdata; end
        else begin n.dd = 1; n.drd = m.we ? 32'h0 : readdata; end
        n.phase = 2;
      end else if (m.stalls + 1 >= MAXW) begin
        n.err = 1;
        if (m.fetch) begin n.fd = 1; n.frd = 0; end
        else begin n.dd = 1; n.drd = 0; end
        n.phase = 2;
      end else begin
        n.stalls = m.stalls + 1;
      end
    end else begin
      n.phase = 0;
    end
    return n;
  endfunction

  function automatic out_t mout(mdl_t m);
    return eo((m.phase == 1) && !m.we, (m.phase == 1) && m.we, m.addr, m.wdata, m.be,
              m.fd, m.frd, m.dd, m.drd, m.phase != 0, m.err);
  endfunction

  vec_t tbl[15];
  mdl_t m0, m1;
  out_t zero_o;

  initial begin
    zero_o = '0;
    tbl[0]  = mk(1, 32'hBFC00000, 0, 0, 0, 0, 4'h0, 0, 32'h3C03BFC0,
                 eo(1, 0, 32'hBFC00000, 0, 4'hF, 0, 0, 0, 0, 1, 0));
    tbl[1]  = mk(1, 32'hBFC00000, 0, 0, 0, 0, 4'h0, 0, 32'h3C03BFC0,
                 eo(0, 0, 0, 0, 4'h0, 1, 32'h3C03BFC0, 0, 0, 1, 0));
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, zero_o);
    tbl[3]  = mk(0, 0, 1, 1, 32'h00001000, 32'hDEADBEEF, 4'h3, 1, 0,
                 eo(0, 1, 32'h00001000, 32'hDEADBEEF, 4'h3, 0, 0, 0, 0, 1, 0));
    tbl[4]  = tbl[3];
    tbl[5]  = tbl[3];
    tbl[6]  = tbl[3];
    tbl[7]  = mk(0, 0, 1, 1, 32'h00001000, 32'hDEADBEEF, 4'h3, 0, 32'h12345678,
                 eo(0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h0, 1, 0));
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, zero_o);
    tbl[9]  = mk(1, 32'hBFC00004, 1, 0, 32'hBFC00028, 0, 4'hF, 0, 0,
                 eo(1, 0, 32'hBFC00028, 0, 4'hF, 0, 0, 0, 0, 1, 0));
    tbl[10] = mk(1, 32'hBFC00004, 1, 0, 32'hBFC00028, 0, 4'hF, 0, 32'h11111111,
                 eo(0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h11111111, 1, 0));
    tbl[11] = mk(1, 32'hBFC00004, 0, 0, 0, 0, 4'h0, 0, 0, zero_o);
    tbl[12] = mk(1, 32'hBFC00004, 0, 0, 0, 0, 4'h0, 0, 0,
                 eo(1, 0, 32'hBFC00004, 0, 4'hF, 0, 0, 0, 0, 1, 0));
    tbl[13] = mk(1, 32'hBFC00004, 0, 0, 0, 0, 4'h0, 0, 32'h22222222,
                 eo(0, 0, 0, 0, 4'h0, 1, 32'h22222222, 0, 0, 1, 0));
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, zero_o);

    // Reset state
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dut0", out0, zero_o, 1);
    check("reset_dut1", out1, zero_o, 1);
    reset = 0;

    // Directed table: single fetch, stalled store, simultaneous requests (data wins)
    for (int i = 0; i < 15; i++) begin
      f_req = tbl[i].f_req; f_addr = tbl[i].f_addr;
      d_req = tbl[i].d_req; d_we = tbl[i].d_we; d_addr = tbl[i].d_addr;
      d_wdata = tbl[i].d_wdata; d_be = tbl[i].d_be;
      waitrequest = tbl[i].wr; readdata = tbl[i].rd;
      @(posedge clk); #1;
      check($sformatf("table_row%0d", i), out0, tbl[i].exp, 0);
    end

    // Watchdog: stuck waitrequest on a fetch; f_rdata previously non-zero
    f_req = 1; f_addr = 32'h00000040; waitrequest = 1; readdata = 32'hFFFFFFFF;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (c < 5) check($sformatf("wdog_stall%0d", c), out0,
                       eo(1, 0, 32'h40, 0, 4'hF, 0, 0, 0, 0, 1, 0), 0);
      else       check("wdog_abort", out0, eo(0, 0, 0, 0, 4'h0, 1, 32'h0, 0, 0, 1, 1), 0);
    end
    f_req = 0; waitrequest = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("wdog_sticky%0d", c), out0, eo(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1), 0);
    end
    pulse_reset();
    check("wdog_cleared", out0, zero_o, 1);

    // Reset in the middle of a stalled load
    d_req = 1; d_we = 0; d_addr = 32'h00002000; d_be = 4'hF; waitrequest = 1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_before", out0, eo(1, 0, 32'h2000, 0, 4'hF, 0, 0, 0, 0, 1, 0), 0);
    #2 reset = 1;
    #1;
    check("midrst_async", out0, zero_o, 1);
    d_req = 0; waitrequest = 0;
    @(negedge clk);
    reset = 0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check($sformatf("midrst_nodone%0d", c), out0, zero_o, 1);
    end
    f_req = 1; f_addr = 32'hBFC00100; readdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    check("midrst_fetch_read", out0, eo(1, 0, 32'hBFC00100, 0, 4'hF, 0, 0, 0, 0, 1, 0), 0);
    @(posedge clk); #1;
    check("midrst_fetch_done", out0, eo(0, 0, 0, 0, 4'h0, 1, 32'hCAFEF00D, 0, 0, 1, 0), 0);
    f_req = 0;

    // FETCH_PRIORITY=1: fetch is served first, data three cycles later
    pulse_reset();
    begin
      int fcyc = -1, dcyc = -1;
      logic [31:0] fdat = 0, ddat = 0;
      f_req = 1; f_addr = 32'hBFC00004;
      d_req = 1; d_we = 0; d_addr = 32'hBFC00028; d_be = 4'hF;
      for (int c = 1; c <= 20; c++) begin
        readdata = 32'hA0000000 + c;
        @(posedge clk); #1;
        if (c == 1) check("prio1_first_grant", out1,
                          eo(1, 0, 32'hBFC00004, 0, 4'hF, 0, 0, 0, 0, 1, 0), 0);
        if (f_done_1 && fcyc < 0) begin fcyc = c; fdat = f_rdata_1; f_req = 0; end
        if (d_done_1 && dcyc < 0) begin dcyc = c; ddat = d_rdata_1; d_req = 0; end
        if (fcyc >= 0 && dcyc >= 0) break;
      end
      check_val("prio1_fdone_cycle", 32'(fcyc), 32'd2);
      check_val("prio1_ddone_cycle", 32'(dcyc), 32'd5);
      check_val("prio1_fdata", fdat, 32'hA0000002);
      check_val("prio1_ddata", ddat, 32'hA0000005);
    end

    // Randomized traffic against the model, both priorities
    for (int ph = 0; ph < 4; ph++) begin
      pulse_reset();
      m0 = mreset();
      m1 = mreset();
      for (int i = 0; i < 500; i++) begin
        f_req = ($urandom_range(0, 99) < 50); f_addr = $urandom;
        d_req = ($urandom_range(0, 99) < 50); d_we = $urandom_range(0, 1);
        d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
        waitrequest = ($urandom_range(0, 99) < 35); readdata = $urandom;
        @(posedge clk);
        m0 = mstep(m0, 1'b0);
        m1 = mstep(m1, 1'b1);
        #1;
        check("rand_dut0", out0, mout(m0), 0);
        check("rand_dut1", out1, mout(m1), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL timeout: got no completion expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_cpu_bus_arbiter.md
# mips_cpu_bus_arbiter

Shares the CPU's single memory bus master port between the instruction-fetch path and the load/store data path. It grants one requester at a time and registers the winning request onto the bus. It holds the transfer stable through `waitrequest`, then returns read data or write completion to the owner with a one-cycle `done` pulse. A watchdog flags bus transfers that stall too long, so a hung memory surfaces as an error rather than a silent timeout.

## Interface
- `FETCH_PRIORITY`, 0: tie-break when both request in the same IDLE cycle. 0 means data wins; 1 means fetch wins.
- `MAX_WAIT`, 255: maximum consecutive `waitrequest`=1 cycles tolerated in ACCESS (1..65535). Reaching it aborts the transfer.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `f_req` in 1: fetch request. Held with `f_addr` until `f_done`.
- `f_addr` in 32: fetch byte address.
- `f_done` out 1: one-cycle pulse; the fetch transfer is complete.
- `f_rdata` out 32: fetched word; valid while `f_done`=1.
- `d_req` in 1: data request. Held with its payload until `d_done`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_be` in 4: byte enables.
- `d_done` out 1: one-cycle pulse; the load or store is complete.
- `d_rdata` out 32: load data; valid while `d_done`=1. It is 0 for stores.
- `address` out 32: bus address.
- `write` out 1: bus write strobe.
- `read` out 1: bus read strobe.
- `waitrequest` in 1: memory stall.
- `writedata` out 32: bus write data.
- `byteenable` out 4: bus byte enables.
- `readdata` in 32: bus read data.
- `busy` out 1: high in ACCESS and DONE.
- `error` out 1: sticky watchdog flag; cleared only by `reset`.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - If no request is present, stay in IDLE.
  - Otherwise pick a winner by `FETCH_PRIORITY`, latch its address, data, byte enables and direction into output registers, record the owner, and go to ACCESS.
  - A fetch always drives `byteenable`=4'b1111 and `write`=0.
- **ACCESS**
  - `read` or `write` is 1. `address`, `writedata` and `byteenable` are frozen.
  - While `waitrequest`=1, increment the wait counter.
  - On an edge with `waitrequest`=0:
    - capture `readdata` into the owner's rdata register (the data port loads 0 for stores);
    - clear `read` and `write`;
    - set the owner's `done`;
    - go to DONE.
  - If the wait counter reaches `MAX_WAIT` on an edge where `waitrequest` is still 1:
    - set `error`;
    - clear strobes;
    - pulse the owner's `done` with rdata=0;
    - go to DONE.
- **DONE**
  - `done` is high for exactly this cycle.
  - `f_req` and `d_req` are ignored. The requester drops `req` in response to `done`, or re-presents a new request, which is evaluated in IDLE.
  - Clear `done` and the wait counter, then go to IDLE.
- Requests and payloads are sampled only in IDLE. Input changes during ACCESS or DONE have no effect on the bus.
- Addresses pass through unmodified; alignment is the requester's responsibility.
- The losing requester waits. No request is dropped while its `req` stays high.

## Timing
- Reset values:
  - state IDLE;
  - `address`, `writedata` = 0;
  - `byteenable` = 4'b0000;
  - `read`, `write`, `f_done`, `d_done`, `busy`, `error` = 0;
  - `f_rdata`, `d_rdata` = 0;
  - wait counter = 0.
- Asserting `reset` mid-ACCESS drops `read` and `write` asynchronously. No `done` pulse is produced.
- Request sampled at edge N:
  - strobe is visible after edge N;
  - earliest `done` is after edge N+1 (zero-wait memory);
  - return to IDLE at edge N+2;
  - next grant sampled at edge N+3.
  - The minimum transfer period is 3 cycles.
- Each `waitrequest`=1 cycle extends ACCESS by one cycle. Strobe and payload stay constant throughout.
- Watchdog: `waitrequest` held high through edges N+1..N+MAX_WAIT gives the abort at edge N+MAX_WAIT. `error` is visible from that edge onward.
- At most one of `f_done` and `d_done` is high in any cycle.
- `busy`=0 implies `read`=`write`=0.

## Test plan
- **Single fetch**
  - Stimulus: `f_req` with `f_addr`=32'hBFC00000; memory returns 32'h3C03BFC0 with `waitrequest`=0.
  - Required: `read`=1 for 1 cycle with `byteenable`=4'b1111; `f_done` is a 1-cycle pulse with `f_rdata`=32'h3C03BFC0; `error`=0.
- **Simultaneous requests, `FETCH_PRIORITY`=0**
  - Stimulus: `d_req` load at 32'hBFC00028 and `f_req` at 32'hBFC00004 in the same IDLE cycle.
  - Required: data transfer first, `d_done` first; the fetch is granted 3 cycles later; `f_done` follows.
  - Repeat with `FETCH_PRIORITY`=1: the order reverses.
- **Stalled store**
  - Stimulus: `d_we`=1, `d_addr`=32'h00001000, `d_wdata`=32'hDEADBEEF, `d_be`=4'b0011, `waitrequest` high for 3 cycles.
  - Required: `write` high for 4 consecutive cycles; `writedata` and `byteenable` stable; `d_done` once with `d_rdata`=0.
- **Watchdog**
  - Stimulus: `MAX_WAIT`=4; fetch issued with `waitrequest` stuck high.
  - Required: abort after 4 stall cycles; `read` drops; `f_done` with `f_rdata`=0; `error` stays 1 until `reset`.
- **Reset mid-transfer**
  - Stimulus: assert `reset` during the second stall cycle of a load.
  - Required: `read` falls without waiting for a clock; no `done`; all outputs at reset values; after release, a new fetch completes normally.
